// File: rtl/can_pkg.sv
// Shared CAN types and constants: FSM states, error codes, field lengths, CRC-15 step.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SOF, ST_ID, ST_CTRL, ST_DATA, ST_CRC,
    ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_CRC   = 2'b10;
  localparam logic [1:0] ERR_FORM  = 2'b11;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int DATA_W    = 8;
  localparam int CRC_W     = 15;
  localparam int EOF_LEN   = 7;
  localparam int STUFF_RUN = 5;
  localparam int CTRL_W    = 3 + DLC_W;
  localparam int ERR_IDLE_BITS = 11;

  function automatic logic [CRC_W-1:0] crc15_next(input logic [CRC_W-1:0] crc, input logic b);
    logic [CRC_W-1:0] sh;
    sh = {crc[CRC_W-2:0], 1'b0};
    return (b ^ crc[CRC_W-1]) ? (sh ^ CRC15_POLY) : sh;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register, one bit per bit_en; clear has priority.
module can_crc15
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (bit_en) begin
      crc <= crc15_next(crc, bit_in);
    end
  end

endmodule

// File: rtl/can_rx.sv
// CAN standard-ID single-byte frame receiver; valid/err one cycle after the deciding sample, no backpressure.
// Optional CAN_RX_ACK_EN adds ack_tx, driven dominant for the ACK slot of a CRC-clean frame.
module can_rx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ID_W-1:0]   id_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
`ifdef CAN_RX_ACK_EN
  ,
  output logic              ack_tx
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       RUN_MAX   = 3'(STUFF_RUN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_d, fall;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             bit_cnt;
  logic [3:0]             rec_cnt;
  logic                   run_val;
  logic [2:0]             run_cnt;
  logic [ID_W-1:0]        id_sh;
  logic [DATA_W-1:0]      data_sh;
  logic [CRC_W-2:0]       crc_sh;
  logic [CRC_W-1:0]       crc;
  logic                   sample, stuff_zone, is_stuff, stuff_err, bit_ok, crc_en;
  logic [1:0]             fault_code;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d   <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_d & ~rx_s;

  // A pending stuff bit may follow the last CRC bit, so the delimiter state still checks one.
  assign sample     = (state != ST_IDLE) && (cnt == '0);
  assign stuff_zone = (state inside {ST_ID, ST_CTRL, ST_DATA, ST_CRC}) ||
                      (state == ST_CRC_DEL && run_cnt == RUN_MAX);
  assign is_stuff   = sample && stuff_zone && (run_cnt == RUN_MAX);
  assign stuff_err  = is_stuff && (rx_s == run_val);
  assign bit_ok     = sample && !is_stuff;
  assign crc_en     = bit_ok && (state inside {ST_SOF, ST_ID, ST_CTRL, ST_DATA});

  can_crc15 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_IDLE && fall),
    .bit_en (crc_en),
    .bit_in (rx_s),
    .crc    (crc)
  );

  // Control field must read RTR=IDE=r0=0, DLC=0001: only its last bit is recessive.
  always_comb begin
    fault_code = ERR_NONE;
    if (stuff_err) begin
      fault_code = ERR_STUFF;
    end else if (bit_ok) begin
      case (state)
        ST_CTRL:    if (rx_s != (bit_cnt == 4'(CTRL_W - 1))) fault_code = ERR_FORM;
        ST_CRC:     if (bit_cnt == 4'(CRC_W - 1) && {crc_sh, rx_s} != crc) fault_code = ERR_CRC;
        ST_CRC_DEL, ST_ACK_DEL, ST_EOF: if (!rx_s) fault_code = ERR_FORM;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      rec_cnt  <= '0;
      run_val  <= 1'b1;
      run_cnt  <= '0;
      id_sh    <= '0;
      data_sh  <= '0;
      crc_sh   <= '0;
      id_out   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (state != ST_IDLE) cnt <= (cnt == '0) ? LAST_CNT : cnt - 1'b1;

      if (sample && stuff_zone) begin
        if (is_stuff || rx_s != run_val) begin
          run_val <= rx_s;
          run_cnt <= 3'd1;
        end else begin
          run_cnt <= run_cnt + 3'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_SOF;
            busy  <= 1'b1;
            cnt   <= FIRST_CNT;
          end
        end
        ST_ERR: begin
          if (sample) begin
            if (!rx_s) begin
              rec_cnt <= '0;
            end else if (rec_cnt == 4'(ERR_IDLE_BITS - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              rec_cnt <= rec_cnt + 4'd1;
            end
          end
        end
        default: begin
          if (fault_code != ERR_NONE) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= fault_code;
            rec_cnt  <= '0;
          end else if (bit_ok) begin
            bit_cnt <= bit_cnt + 4'd1;
            case (state)
              ST_SOF: begin
                bit_cnt <= '0;
                run_val <= 1'b0;
                run_cnt <= 3'd1;
                if (!rx_s) begin
                  state <= ST_ID;
                end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end
              end
              ST_ID: begin
                id_sh <= {id_sh[ID_W-2:0], rx_s};
                if (bit_cnt == 4'(ID_W - 1)) begin
                  state   <= ST_CTRL;
                  bit_cnt <= '0;
                end
              end
              ST_CTRL: begin
                if (bit_cnt == 4'(CTRL_W - 1)) begin
                  state   <= ST_DATA;
                  bit_cnt <= '0;
                end
              end
              ST_DATA: begin
                data_sh <= {data_sh[DATA_W-2:0], rx_s};
                if (bit_cnt == 4'(DATA_W - 1)) begin
                  state   <= ST_CRC;
                  bit_cnt <= '0;
                end
              end
              ST_CRC: begin
                crc_sh <= {crc_sh[CRC_W-3:0], rx_s};
                if (bit_cnt == 4'(CRC_W - 1)) state <= ST_CRC_DEL;
              end
              ST_CRC_DEL: state <= ST_ACK;
              ST_ACK:     state <= ST_ACK_DEL;
              ST_ACK_DEL: begin
                state   <= ST_EOF;
                bit_cnt <= '0;
              end
              ST_EOF: begin
                if (bit_cnt == 4'(EOF_LEN - 1)) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  valid    <= 1'b1;
                  id_out   <= id_sh;
                  data_out <= data_sh;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

`ifdef CAN_RX_ACK_EN
  localparam logic [CNT_W-1:0] EDGE_CNT = CNT_W'(CLKS_PER_BIT / 2);

  // ACK is only reachable after a matching CRC; the slot spans edge-to-edge, half a bit before each sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_tx <= 1'b1;
    end else if (state == ST_ACK && cnt == EDGE_CNT) begin
      ack_tx <= 1'b0;
    end else if (state != ST_ACK && (state != ST_ACK_DEL || cnt == EDGE_CNT)) begin
      ack_tx <= 1'b1;
    end
  end
`endif

endmodule
